id_ex_alu_issue: RTL and testbench

//  ID/EX pipeline stage that drives the 32-bit ripple ALU built from 1-bit slices.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/alu_decode.sv | 105 ++++++++++
 rtl/id_ex_alu_issue.sv | 150 +++++++++++++++
 tb/tb_id_ex_alu_issue.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the ID/EX issue stage: ALU slice control codes, MIPS opcode/funct
// constants and the latched EX control bundle.
package mips_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic       regwr;
        logic       memrd;
        logic       memwr;
        logic       branch;
        logic       ovf_en;
        logic       illegal;
        logic [3:0] alu_ctrl;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NOP = '0;

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt_op(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ID decode: opcode/funct to EX control bundle, immediate handling and
// operand-routing hints.
module alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ex_ctrl_t   ctrl,
    output logic       imm_zext,
    output logic       use_imm,
    output logic       dst_rt,
    output logic       reads_rt
);

    always_comb begin
        ctrl     = EX_CTRL_NOP;
        imm_zext = 1'b0;
        use_imm  = 1'b0;
        dst_rt   = 1'b1;
        reads_rt = reads_rt_op(opcode);
        case (opcode)
            OP_RTYPE: begin
                dst_rt     = 1'b0;
                ctrl.regwr = 1'b1;
                case (funct)
                    FN_ADD: begin
                        ctrl.alu_ctrl = ALU_ADD;
                        ctrl.ovf_en   = 1'b1;
                    end
                    FN_ADDU: ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB: begin
                        ctrl.alu_ctrl = ALU_SUB;
                        ctrl.ovf_en   = 1'b1;
                    end
                    FN_SUBU: ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:  ctrl.alu_ctrl = ALU_AND;
                    FN_OR:   ctrl.alu_ctrl = ALU_OR;
                    FN_XOR:  ctrl.alu_ctrl = ALU_XOR;
                    FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
                    FN_SLTU: ctrl.alu_ctrl = ALU_SLTU;
                    default: begin
                        ctrl.regwr   = 1'b0;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                ctrl.regwr    = 1'b1;
                ctrl.ovf_en   = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                use_imm       = 1'b1;
            end
            OP_ADDIU: begin
                ctrl.regwr    = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                use_imm       = 1'b1;
            end
            OP_SLTI: begin
                ctrl.regwr    = 1'b1;
                ctrl.alu_ctrl = ALU_SLT;
                use_imm       = 1'b1;
            end
            OP_SLTIU: begin
                ctrl.regwr    = 1'b1;
                ctrl.alu_ctrl = ALU_SLTU;
                use_imm       = 1'b1;
            end
            OP_ANDI: begin
                ctrl.regwr    = 1'b1;
                ctrl.alu_ctrl = ALU_AND;
                use_imm       = 1'b1;
                imm_zext      = 1'b1;
            end
            OP_ORI: begin
                ctrl.regwr    = 1'b1;
                ctrl.alu_ctrl = ALU_OR;
                use_imm       = 1'b1;
                imm_zext      = 1'b1;
            end
            OP_XORI: begin
                ctrl.regwr    = 1'b1;
                ctrl.alu_ctrl = ALU_XOR;
                use_imm       = 1'b1;
                imm_zext      = 1'b1;
            end
            OP_LW: begin
                ctrl.regwr    = 1'b1;
                ctrl.memrd    = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                use_imm       = 1'b1;
            end
            OP_SW: begin
                ctrl.memwr    = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                use_imm       = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register feeding the ripple ALU: decode, operand latch, EX/MEM and MEM/WB
// forwarding, and load-use bubble insertion.
module id_ex_alu_issue
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [15:0]      id_imm,
    input  logic             stall,
    input  logic             flush,
    input  logic             exm_wr,
    input  logic [RA_W-1:0]  exm_rd,
    input  logic [WIDTH-1:0] exm_data,
    input  logic             mwb_wr,
    input  logic [RA_W-1:0]  mwb_rd,
    input  logic [WIDTH-1:0] mwb_data,
    output logic             hz_stall,
    output logic             ex_valid,
    output logic [3:0]       alu_ctrl,
    output logic             alu_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [RA_W-1:0]  ex_dst,
    output logic             ex_regwr,
    output logic             ex_memrd,
    output logic             ex_memwr,
    output logic             ex_branch,
    output logic             ex_ovf_en,
    output logic [WIDTH-1:0] ex_store,
    output logic             ex_illegal
);

    ex_ctrl_t         id_ctrl;
    logic             id_imm_zext;
    logic             id_use_imm;
    logic             id_dst_rt;
    logic             id_reads_rt;
    logic [WIDTH-1:0] id_imm_ext;

    alu_decode u_alu_decode (
        .opcode   (id_opcode),
        .funct    (id_funct),
        .ctrl     (id_ctrl),
        .imm_zext (id_imm_zext),
        .use_imm  (id_use_imm),
        .dst_rt   (id_dst_rt),
        .reads_rt (id_reads_rt)
    );

    assign id_imm_ext = {{(WIDTH-16){id_imm[15] & ~id_imm_zext}}, id_imm};

    logic             valid_q;
    ex_ctrl_t         ctrl_q;
    logic [RA_W-1:0]  rs_q;
    logic [RA_W-1:0]  rt_q;
    logic [RA_W-1:0]  dst_q;
    logic [WIDTH-1:0] rs_data_q;
    logic [WIDTH-1:0] rt_data_q;
    logic [WIDTH-1:0] imm_q;
    logic             use_imm_q;

    // Load-use: the load in EX cannot deliver its data before the consumer in ID reaches EX.
    logic rs_conflict;
    logic rt_conflict;

    assign rs_conflict = (dst_q == id_rs);
    assign rt_conflict = id_reads_rt && (dst_q == id_rt);
    assign hz_stall    = !flush && valid_q && ctrl_q.memrd && (dst_q != '0) && id_valid
                         && (rs_conflict || rt_conflict);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= EX_CTRL_NOP;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= EX_CTRL_NOP;
        end else if (!stall) begin
            if (hz_stall) begin
                valid_q <= 1'b0;
                ctrl_q  <= EX_CTRL_NOP;
            end else begin
                valid_q   <= id_valid;
                ctrl_q    <= id_valid ? id_ctrl : EX_CTRL_NOP;
                rs_q      <= id_rs;
                rt_q      <= id_rt;
                dst_q     <= id_dst_rt ? id_rt : id_rd;
                rs_data_q <= id_rs_data;
                rt_data_q <= id_rt_data;
                imm_q     <= id_imm_ext;
                use_imm_q <= id_use_imm;
            end
        end
    end

    // EX/MEM is the younger producer, so it is tested first; r0 is hard-wired and never forwarded.
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    always_comb begin
        fwd_a = rs_data_q;
        if (exm_wr && (exm_rd != '0) && (exm_rd == rs_q)) begin
            fwd_a = exm_data;
        end else if (mwb_wr && (mwb_rd != '0) && (mwb_rd == rs_q)) begin
            fwd_a = mwb_data;
        end
    end

    always_comb begin
        fwd_b = rt_data_q;
        if (exm_wr && (exm_rd != '0) && (exm_rd == rt_q)) begin
            fwd_b = exm_data;
        end else if (mwb_wr && (mwb_rd != '0) && (mwb_rd == rt_q)) begin
            fwd_b = mwb_data;
        end
    end

    assign ex_valid   = valid_q;
    assign alu_ctrl   = ctrl_q.alu_ctrl;
    assign alu_cin    = ctrl_q.alu_ctrl[3];
    assign alu_a      = fwd_a;
    assign alu_b      = use_imm_q ? imm_q : fwd_b;
    assign ex_store   = fwd_b;
    assign ex_dst     = dst_q;
    assign ex_regwr   = ctrl_q.regwr;
    assign ex_memrd   = ctrl_q.memrd;
    assign ex_memwr   = ctrl_q.memwr;
    assign ex_branch  = ctrl_q.branch;
    assign ex_ovf_en  = ctrl_q.ovf_en;
    assign ex_illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed and randomized bench for id_ex_alu_issue against an instruction-level model of the
// EX stage contents.
module tb_id_ex_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm;
    logic        stall;
    logic        flush;
    logic        exm_wr;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        mwb_wr;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic        hz_stall;
    logic        ex_valid;
    logic [3:0]  alu_ctrl;
    logic        alu_cin;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  ex_dst;
    logic        ex_regwr;
    logic        ex_memrd;
    logic        ex_memwr;
    logic        ex_branch;
    logic        ex_ovf_en;
    logic [31:0] ex_store;
    logic        ex_illegal;

    id_ex_alu_issue #(.WIDTH(32), .RA_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_funct   (id_funct),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm     (id_imm),
        .stall      (stall),
        .flush      (flush),
        .exm_wr     (exm_wr),
        .exm_rd     (exm_rd),
        .exm_data   (exm_data),
        .mwb_wr     (mwb_wr),
        .mwb_rd     (mwb_rd),
        .mwb_data   (mwb_data),
        .hz_stall   (hz_stall),
        .ex_valid   (ex_valid),
        .alu_ctrl   (alu_ctrl),
        .alu_cin    (alu_cin),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .ex_dst     (ex_dst),
        .ex_regwr   (ex_regwr),
        .ex_memrd   (ex_memrd),
        .ex_memwr   (ex_memwr),
        .ex_branch  (ex_branch),
        .ex_ovf_en  (ex_ovf_en),
        .ex_store   (ex_store),
        .ex_illegal (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference decode: one row per instruction, straight from the instruction table.
    // imm_kind: 0 = register operand B, 1 = sign-extended imm, 2 = zero-extended imm.
    typedef struct packed {
        bit       ok;
        bit [3:0] ctrl;
        bit       regwr;
        bit       memrd;
        bit       memwr;
        bit       branch;
        bit       ovf;
        bit [1:0] imm_kind;
    } dec_t;

    function automatic dec_t row(bit [3:0] c, bit w, bit r, bit s, bit b, bit o, bit [1:0] k);
        dec_t d;
        d = {1'b1, c, w, r, s, b, o, k};
        return d;
    endfunction

    function automatic dec_t ref_dec(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d = '0;
        if (op == 6'h00) begin
            if (fn == 6'h20) d = row(4'd2, 1, 0, 0, 0, 1, 0);
            if (fn == 6'h21) d = row(4'd2, 1, 0, 0, 0, 0, 0);
            if (fn == 6'h22) d = row(4'd10, 1, 0, 0, 0, 1, 0);
            if (fn == 6'h23) d = row(4'd10, 1, 0, 0, 0, 0, 0);
            if (fn == 6'h24) d = row(4'd0, 1, 0, 0, 0, 0, 0);
            if (fn == 6'h25) d = row(4'd1, 1, 0, 0, 0, 0, 0);
            if (fn == 6'h26) d = row(4'd3, 1, 0, 0, 0, 0, 0);
            if (fn == 6'h2A) d = row(4'd11, 1, 0, 0, 0, 0, 0);
            if (fn == 6'h2B) d = row(4'd12, 1, 0, 0, 0, 0, 0);
        end
        if (op == 6'h08) d = row(4'd2, 1, 0, 0, 0, 1, 1);
        if (op == 6'h09) d = row(4'd2, 1, 0, 0, 0, 0, 1);
        if (op == 6'h0A) d = row(4'd11, 1, 0, 0, 0, 0, 1);
        if (op == 6'h0B) d = row(4'd12, 1, 0, 0, 0, 0, 1);
        if (op == 6'h0C) d = row(4'd0, 1, 0, 0, 0, 0, 2);
        if (op == 6'h0D) d = row(4'd1, 1, 0, 0, 0, 0, 2);
        if (op == 6'h0E) d = row(4'd3, 1, 0, 0, 0, 0, 2);
        if (op == 6'h23) d = row(4'd2, 1, 1, 0, 0, 0, 1);
        if (op == 6'h2B) d = row(4'd2, 0, 0, 1, 0, 0, 1);
        if (op == 6'h04) d = row(4'd10, 0, 0, 0, 1, 0, 0);
        return d;
    endfunction

    // Model of what the EX stage holds: the instruction as it was presented in ID.
    bit          m_valid;
    logic [5:0]  m_op;
    logic [5:0]  m_fn;
    logic [4:0]  m_rs;
    logic [4:0]  m_rt;
    logic [4:0]  m_rd;
    logic [31:0] m_rsd;
    logic [31:0] m_rtd;
    logic [15:0] m_imm;
    logic        last_hz;

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (src == 0) return rf;
        if (exm_wr && exm_rd == src) return exm_data;
        if (mwb_wr && mwb_rd == src) return mwb_data;
        return rf;
    endfunction

    function automatic logic [4:0] ref_dst();
        return (m_op == 6'h00) ? m_rd : m_rt;
    endfunction

    function automatic logic ref_hz();
        dec_t d;
        logic [4:0] dst;
        bit reads_rt;
        d = ref_dec(m_op, m_fn);
        dst = ref_dst();
        reads_rt = (id_opcode == 6'h00) || (id_opcode == 6'h2B) || (id_opcode == 6'h04);
        return !flush && m_valid && d.memrd && dst != 0 && id_valid
               && (dst == id_rs || (reads_rt && dst == id_rt));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        dec_t d;
        logic [31:0] b_reg;
        logic [31:0] b_exp;
        check("ex_valid", ex_valid, m_valid);
        if (!m_valid) begin
            check("bubble alu_ctrl", alu_ctrl, 0);
            check("bubble alu_cin", alu_cin, 0);
            check("bubble ctl", {ex_regwr, ex_memrd, ex_memwr, ex_branch, ex_ovf_en, ex_illegal}, 0);
        end else begin
            d = ref_dec(m_op, m_fn);
            b_reg = ref_fwd(m_rt, m_rtd);
            if (d.imm_kind == 0) b_exp = b_reg;
            else if (d.imm_kind == 2 || m_imm < 16'h8000) b_exp = 32'(m_imm);
            else b_exp = 32'(m_imm) + 32'hFFFF0000;
            check("alu_ctrl", alu_ctrl, d.ctrl);
            check("alu_cin", alu_cin, (d.ctrl == 10 || d.ctrl == 11 || d.ctrl == 12));
            check("alu_a", alu_a, ref_fwd(m_rs, m_rsd));
            check("alu_b", alu_b, b_exp);
            check("ex_store", ex_store, b_reg);
            check("ex_dst", ex_dst, ref_dst());
            check("ex_regwr", ex_regwr, d.regwr);
            check("ex_memrd", ex_memrd, d.memrd);
            check("ex_memwr", ex_memwr, d.memwr);
            check("ex_branch", ex_branch, d.branch);
            check("ex_ovf_en", ex_ovf_en, d.ovf);
            check("ex_illegal", ex_illegal, !d.ok);
        end
    endtask

    // One clock: check the combinational hazard request, clock, advance the model, check EX.
    task automatic step();
        logic exp_hz;
        #1;
        exp_hz = ref_hz();
        last_hz = hz_stall;
        check("hz_stall", hz_stall, exp_hz);
        @(posedge clk);
        if (flush) m_valid = 0;
        else if (stall) m_valid = m_valid;
        else if (exp_hz) m_valid = 0;
        else begin
            m_valid = id_valid;
            m_op = id_opcode;
            m_fn = id_funct;
            m_rs = id_rs;
            m_rt = id_rt;
            m_rd = id_rd;
            m_rsd = id_rs_data;
            m_rtd = id_rt_data;
            m_imm = id_imm;
        end
        #1;
        check_outputs();
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [15:0] imm);
        id_valid = 1;
        id_opcode = op;
        id_funct = fn;
        id_rs = rs;
        id_rt = rt;
        id_rd = rd;
        id_rs_data = rsd;
        id_rt_data = rtd;
        id_imm = imm;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] md);
        exm_wr = ew;
        exm_rd = erd;
        exm_data = ed;
        mwb_wr = mw;
        mwb_rd = mrd;
        mwb_data = md;
    endtask

    logic [5:0] op_tab [13] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04};
    logic [5:0] fn_tab [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};

    initial begin
        m_valid = 0;
        m_op = 0; m_fn = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;

        // Reset with every input high.
        rst_n = 0;
        set_id(6'h3F, 6'h3F, 5'h1F, 5'h1F, 5'h1F, '1, '1, '1);
        stall = 1; flush = 1;
        set_fwd(1, 5'h1F, '1, 1, 5'h1F, '1);
        #12;
        check("reset ex_valid", ex_valid, 0);
        check("reset alu_ctrl", alu_ctrl, 0);
        check("reset hz_stall", hz_stall, 0);
        check("reset alu_a", alu_a, 0);
        check("reset alu_b", alu_b, 0);
        stall = 0; flush = 0;
        set_fwd(0, 0, 0, 0, 0, 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // addu r3,r1,r2
        set_id(6'h00, 6'h21, 1, 2, 3, 32'd10, 32'd20, 0);
        step();
        check("addu ctrl", alu_ctrl, 2);
        check("addu cin", alu_cin, 0);

        // sub r4,r5,r6 with 7 - 3
        set_id(6'h00, 6'h22, 5, 6, 4, 32'd7, 32'd3, 0);
        step();
        check("sub ctrl", alu_ctrl, 10);
        check("sub cin", alu_cin, 1);
        check("sub a", alu_a, 7);
        check("sub b", alu_b, 3);
        check("sub ovf", ex_ovf_en, 1);

        // Zero- vs sign-extended immediates.
        set_id(6'h0C, 0, 1, 2, 0, 32'h55, 32'h66, 16'h8001);
        step();
        check("andi imm", alu_b, 32'h00008001);
        set_id(6'h0A, 0, 1, 2, 0, 32'h55, 32'h66, 16'h8001);
        step();
        check("slti imm", alu_b, 32'hFFFF8001);
        check("slti ctrl", alu_ctrl, 11);

        // Load-use: lw r2 then add r3,r2,r1.
        set_id(6'h23, 0, 1, 2, 0, 32'h100, 0, 16'h4);
        step();
        set_id(6'h00, 6'h20, 2, 1, 3, 32'hDEAD, 32'h5, 0);
        step();
        check("lu hz pulse", last_hz, 1);
        check("lu bubble", ex_valid, 0);
        set_fwd(1, 2, 32'h0, 0, 0, 0);
        step();
        check("lu hz once", last_hz, 0);
        set_fwd(0, 0, 0, 1, 2, 32'hCAFEF00D);
        #1;
        check("lu mwb fwd", alu_a, 32'hCAFEF00D);

        // EX/MEM beats MEM/WB; r0 never forwards.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(6'h00, 6'h21, 5, 0, 7, 32'h11, 0, 0);
        step();
        set_fwd(1, 5, 32'hAA, 1, 5, 32'hBB);
        #1;
        check("fwd prio", alu_a, 32'hAA);
        set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
        set_id(6'h00, 6'h21, 0, 0, 7, 0, 0, 0);
        step();
        check("fwd r0", alu_a, 0);
        set_fwd(0, 0, 0, 0, 0, 0);

        // flush beats stall; illegal funct.
        set_id(6'h00, 6'h21, 1, 2, 3, 1, 2, 0);
        flush = 1; stall = 1;
        step();
        check("flush+stall", ex_valid, 0);
        flush = 0; stall = 0;
        set_id(6'h00, 6'h3F, 1, 2, 3, 1, 2, 0);
        step();
        check("illegal", ex_illegal, 1);
        check("illegal regwr", ex_regwr, 0);

        // Reset while a load-use hazard is being held by an external stall.
        set_id(6'h23, 0, 1, 9, 0, 0, 0, 0);
        step();
        set_id(6'h2B, 0, 4, 9, 0, 0, 0, 0);
        stall = 1;
        step();
        check("held hz", last_hz, 1);
        rst_n = 0;
        m_valid = 0;
        #1;
        check("rst hz_stall", hz_stall, 0);
        check("rst ex_valid", ex_valid, 0);
        stall = 0;
        #1;
        rst_n = 1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 5) != 0);
            id_opcode = ($urandom_range(0, 15) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 12)];
            id_funct = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 8)];
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_rs_data = $urandom;
            id_rt_data = $urandom;
            id_imm = 16'($urandom);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
